main_store_serial: RTL and testbench
====================================

Name: main_store_serial

Overview:
- Serial main store that answers the data-flow gates. It is the responder end of the store transfer path: the outward path reads a line out bit-serially, and the inward path writes a line in bit-serially.
- Holds LINES words of WORD_BITS bits. Transfers are aligned to a free-running beat counter, so each transfer is one full word period, LSB first.
- Sits between the inward/outward transfer gates and the control/accumulator logic.

Parameters:
- WORD_BITS, 32, bits per store line and beats per word period.
- LINES, 32, number of store lines.
- ADDR_W, 5, line address width; must satisfy 2**ADDR_W >= LINES.

Ports:
- w_CLK, input, 1, system clock; one beat per cycle.
- w_RST_N, input, 1, asynchronous active-low reset.
- w_MS_REQ, input, 1, transfer request; sampled only in IDLE.
- w_MS_WRITE, input, 1, 1 = inward write, 0 = outward read; latched with the request.
- w_MS_ADDR, input, ADDR_W, line address; latched with the request.
- w_MS_DATA_IN, input, 1, serial write bit, LSB first, sampled during XFER.
- w_MS_ERASE, input, 1, S-erase waveform; while high during a write XFER, the stored bit is forced to 0.
- w_MS_DATA_OUT, output, 1, serial read bit, LSB first.
- w_MS_DATA_VALID, output, 1, high on every XFER beat.
- w_MS_BUSY, output, 1, high in WAIT_SYNC, XFER and DONE.
- w_MS_DONE, output, 1, one-cycle pulse after the last beat.
- w_BEAT, output, clog2(WORD_BITS), current beat index.
- w_BEAT_0, output, 1, high when w_BEAT == 0.

Behaviour:
- Reset (async, w_RST_N = 0):
  - State goes to IDLE and the beat counter to 0.
  - All store bits are cleared to 0 and the latched address, write flag and outputs are cleared to 0.
  - Reset asserted mid-transfer aborts it: no DONE pulse, and any partially written line keeps its cleared value.
- Beat counter: free-running 0..WORD_BITS-1, wraps to 0, increments every cycle after reset release. w_BEAT_0 is combinational from the counter.
- States:
  - IDLE: when w_MS_REQ = 1, latch w_MS_ADDR and w_MS_WRITE and go to WAIT_SYNC.
  - WAIT_SYNC: when w_BEAT == WORD_BITS-1, go to XFER. Otherwise stay.
  - XFER: one cycle per beat, bit index = w_BEAT (0..WORD_BITS-1). After the beat WORD_BITS-1 cycle, go to DONE.
  - DONE: w_MS_DONE = 1 for one cycle, then IDLE.
- Latency:
  - A request accepted at beat b enters WAIT_SYNC at beat b+1 and XFER at the next beat 0.
  - Request at beat 30 gives the first data at beat 0, 2 cycles later.
  - Request at beat WORD_BITS-1 waits a full word period, so the first data comes WORD_BITS+1 cycles later.
- Read (w_MS_WRITE latched 0):
  - w_MS_DATA_OUT = store[addr][w_BEAT], combinational, during XFER.
  - w_MS_DATA_OUT is 0 in every other state.
- Write (w_MS_WRITE latched 1):
  - On each XFER clock edge, store[addr][w_BEAT] <= w_MS_DATA_IN & ~w_MS_ERASE.
  - w_MS_DATA_OUT stays 0 during a write.
- w_MS_DATA_VALID = 1 exactly in XFER: WORD_BITS consecutive cycles per transfer.
- w_MS_REQ is ignored whenever w_MS_BUSY = 1, including the DONE cycle. A request held high through DONE is accepted on the following IDLE cycle.
- Address, write flag and data inputs change only while IDLE or between transfers. Changes to w_MS_ADDR or w_MS_WRITE after acceptance have no effect.
- An address >= LINES is a no-op: reads return 0, writes are discarded, and the handshake timing is unchanged.
- The store is not modified outside write XFER cycles. There are no simultaneous read and write.

Test Plan:
- Reset then idle: after w_RST_N rises, w_BEAT counts 0,1,...,31,0. w_BEAT_0 pulses every 32 cycles. All outputs are 0.
- Write then read: write 32'hDEADBEEF to line 5 (LSB first), then read line 5. w_MS_DATA_OUT serialises to 32'hDEADBEEF, w_MS_DATA_VALID is high for 32 cycles, and w_MS_DONE pulses once per transfer.
- Sync latency: request asserted at beat 30 gives VALID rising 2 cycles later at beat 0. Request at beat 31 gives VALID rising 33 cycles later.
- Erase during write: line 3 holds 32'hFFFFFFFF. Write all-ones with w_MS_ERASE high on beats 8..15. Reading line 3 returns 32'hFFFF00FF.
- Busy rejection: a second request with addr 7 pulsed during an XFER to line 2 is ignored. Line 7 is unchanged and only one DONE pulse occurs.
- Reset mid-write: deassert w_RST_N at beat 10 of a write to line 9. There is no DONE pulse, state is IDLE, and a subsequent read of line 9 returns 0.

Source files
------------

// File: rtl/main_store_serial.sv
// Serial main store: LINES words of WORD_BITS bits, moved one bit per beat,
// LSB first, with every transfer aligned to a free-running beat counter.
module main_store_serial #(
    parameter int WORD_BITS = 32,
    parameter int LINES     = 32,
    parameter int ADDR_W    = 5,
    localparam int BEAT_W   = $clog2(WORD_BITS)
) (
    input  logic              w_CLK,
    input  logic              w_RST_N,
    input  logic              w_MS_REQ,
    input  logic              w_MS_WRITE,
    input  logic [ADDR_W-1:0] w_MS_ADDR,
    input  logic              w_MS_DATA_IN,
    input  logic              w_MS_ERASE,
    output logic              w_MS_DATA_OUT,
    output logic              w_MS_DATA_VALID,
    output logic              w_MS_BUSY,
    output logic              w_MS_DONE,
    output logic [BEAT_W-1:0] w_BEAT,
    output logic              w_BEAT_0
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORD_BITS - 1);
    localparam logic [ADDR_W:0]   LINES_W   = (ADDR_W + 1)'(LINES);

    logic [1:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [LINES-1:0][WORD_BITS-1:0] store_q, store_d;

    logic addr_ok;
    logic in_xfer;

    // Lines beyond LINES are silently ignored but keep normal handshake timing.
    assign addr_ok = ({1'b0, addr_q} < LINES_W);
    assign in_xfer = (state_q == ST_XFER);

    // Free-running beat counter, wraps at the end of each word period.
    always_comb begin
        beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
    end

    // Transfer sequencing; the request is only looked at while idle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (w_MS_REQ) begin
                    addr_d  = w_MS_ADDR;
                    wr_d    = w_MS_WRITE;
                    state_d = ST_WAIT;
                end
            end
            // Hold until the word period restarts so bit index == beat.
            ST_WAIT: if (beat_q == BEAT_LAST) state_d = ST_XFER;
            ST_XFER: if (beat_q == BEAT_LAST) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Store update: one bit per write beat, erase forces the bit to zero.
    always_comb begin
        store_d = store_q;
        if (in_xfer && wr_q && addr_ok)
            store_d[addr_q][beat_q] = w_MS_DATA_IN & ~w_MS_ERASE;
    end

    // State, beat and store registers; reset wipes the whole store.
    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            store_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            store_q <= store_d;
        end
    end

    // Outputs decode directly from state and beat; read data is combinational.
    always_comb begin
        w_MS_DATA_OUT   = (in_xfer && !wr_q && addr_ok) ? store_q[addr_q][beat_q] : 1'b0;
        w_MS_DATA_VALID = in_xfer;
        w_MS_BUSY       = (state_q != ST_IDLE);
        w_MS_DONE       = (state_q == ST_DONE);
        w_BEAT          = beat_q;
        w_BEAT_0        = (beat_q == '0);
    end

endmodule

// File: tb/tb_main_store_serial.sv
// Directed bench for main_store_serial: reset/beat counter, write/read,
// sync latency, erase, busy rejection and reset mid-write.
module tb_main_store_serial;

    logic       w_CLK = 1'b0;
    logic       w_RST_N = 1'b0;
    logic       w_MS_REQ = 1'b0;
    logic       w_MS_WRITE = 1'b0;
    logic [4:0] w_MS_ADDR = '0;
    logic       w_MS_DATA_IN = 1'b0;
    logic       w_MS_ERASE = 1'b0;
    logic       w_MS_DATA_OUT;
    logic       w_MS_DATA_VALID;
    logic       w_MS_BUSY;
    logic       w_MS_DONE;
    logic [4:0] w_BEAT;
    logic       w_BEAT_0;

    int vectors = 0;
    int miscompares = 0;

    main_store_serial #(.WORD_BITS(32), .LINES(32), .ADDR_W(5)) dut (
        .w_CLK(w_CLK), .w_RST_N(w_RST_N), .w_MS_REQ(w_MS_REQ),
        .w_MS_WRITE(w_MS_WRITE), .w_MS_ADDR(w_MS_ADDR),
        .w_MS_DATA_IN(w_MS_DATA_IN), .w_MS_ERASE(w_MS_ERASE),
        .w_MS_DATA_OUT(w_MS_DATA_OUT), .w_MS_DATA_VALID(w_MS_DATA_VALID),
        .w_MS_BUSY(w_MS_BUSY), .w_MS_DONE(w_MS_DONE),
        .w_BEAT(w_BEAT), .w_BEAT_0(w_BEAT_0)
    );

    always #5 w_CLK = ~w_CLK;

    task automatic tick();
        @(posedge w_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_beat(input logic [4:0] b);
        int n;
        n = 0;
        while (w_BEAT !== b && n < 64) begin tick(); n++; end
        check("wait_beat", {27'd0, w_BEAT}, {27'd0, b});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (w_MS_DONE !== 1'b1 && n < 80) begin tick(); n++; end
        check("drain_done", {31'd0, w_MS_DONE}, 32'd1);
        tick();
    endtask

    // One complete transfer; inject pulses a stray request for line 7 mid-XFER.
    task automatic xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic [31:0] emask, input bit inject, output logic [31:0] rdata);
        int n;
        int vcnt;
        w_MS_REQ = 1'b1; w_MS_WRITE = wr; w_MS_ADDR = addr;
        tick();
        w_MS_REQ = 1'b0;
        check("busy_after_req", {31'd0, w_MS_BUSY}, 32'd1);
        n = 0;
        while (w_MS_DATA_VALID !== 1'b1 && n < 40) begin tick(); n++; end
        check("xfer_start_beat", {26'd0, w_MS_DATA_VALID, w_BEAT}, {26'd0, 1'b1, 5'd0});
        rdata = '0;
        vcnt = 0;
        for (int i = 0; i < 32; i++) begin
            w_MS_DATA_IN = wdata[i];
            w_MS_ERASE   = emask[i];
            if (inject && i == 5) begin w_MS_REQ = 1'b1; w_MS_ADDR = 5'd7; end
            if (inject && i == 6) w_MS_REQ = 1'b0;
            rdata[i] = w_MS_DATA_OUT;
            if (w_MS_DATA_VALID === 1'b1) vcnt++;
            tick();
        end
        w_MS_DATA_IN = 1'b0;
        w_MS_ERASE   = 1'b0;
        check("valid_count", vcnt, 32);
        check("done_pulse", {29'd0, w_MS_DONE, w_MS_DATA_VALID, w_MS_BUSY}, 32'b101);
        tick();
        check("after_done", {30'd0, w_MS_DONE, w_MS_BUSY}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int n;
        int dones;

        // Reset state
        tick(); tick();
        check("rst_outputs", {26'd0, w_MS_DATA_OUT, w_MS_DATA_VALID, w_MS_BUSY, w_MS_DONE, w_BEAT_0, 1'b0},
              {26'd0, 5'b00001, 1'b0});
        check("rst_beat", {27'd0, w_BEAT}, 32'd0);
        w_RST_N = 1'b1;
        check("release_beat", {26'd0, w_BEAT_0, w_BEAT}, {26'd0, 1'b1, 5'd0});
        for (int i = 1; i <= 32; i++) begin
            tick();
            check("beat_count", {26'd0, w_BEAT_0, w_BEAT}, {26'd0, (i % 32) == 0, 5'(i % 32)});
            check("idle_outputs", {28'd0, w_MS_DATA_OUT, w_MS_DATA_VALID, w_MS_BUSY, w_MS_DONE}, 32'd0);
        end

        // Write then read line 5
        xfer(1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0, rd);
        check("write_dout_zero", rd, 32'h0);
        xfer(1'b0, 5'd5, 32'h0, 32'h0, 1'b0, rd);
        check("read_line5", rd, 32'hDEADBEEF);
        xfer(1'b0, 5'd6, 32'h0, 32'h0, 1'b0, rd);
        check("read_line6_empty", rd, 32'h0);

        // Request at beat 30: valid two cycles later at beat 0
        wait_beat(5'd30);
        w_MS_REQ = 1'b1; w_MS_WRITE = 1'b0; w_MS_ADDR = 5'd5;
        tick();
        w_MS_REQ = 1'b0;
        check("lat30_cycle1", {26'd0, w_MS_DATA_VALID, w_BEAT}, {26'd0, 1'b0, 5'd31});
        tick();
        check("lat30_cycle2", {26'd0, w_MS_DATA_VALID, w_BEAT}, {26'd0, 1'b1, 5'd0});
        drain();

        // Request at beat 31: valid 33 cycles later
        wait_beat(5'd31);
        w_MS_REQ = 1'b1;
        tick();
        w_MS_REQ = 1'b0;
        n = 1;
        while (w_MS_DATA_VALID !== 1'b1 && n < 60) begin tick(); n++; end
        check("lat31_cycles", n, 33);
        drain();

        // Erase on beats 8..15
        xfer(1'b1, 5'd3, 32'hFFFFFFFF, 32'h0, 1'b0, rd);
        xfer(1'b0, 5'd3, 32'h0, 32'h0, 1'b0, rd);
        check("line3_ones", rd, 32'hFFFFFFFF);
        xfer(1'b1, 5'd3, 32'hFFFFFFFF, 32'h0000FF00, 1'b0, rd);
        xfer(1'b0, 5'd3, 32'h0, 32'h0, 1'b0, rd);
        check("erase_line3", rd, 32'hFFFF00FF);

        // Busy rejection: stray request for line 7 during write to line 2
        xfer(1'b1, 5'd2, 32'h12345678, 32'h0, 1'b1, rd);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (w_MS_DONE === 1'b1 || w_MS_BUSY === 1'b1) dones++;
            tick();
        end
        check("no_second_xfer", dones, 0);
        xfer(1'b0, 5'd7, 32'h0, 32'h0, 1'b0, rd);
        check("line7_unchanged", rd, 32'h0);
        xfer(1'b0, 5'd2, 32'h0, 32'h0, 1'b0, rd);
        check("line2_written", rd, 32'h12345678);

        // Reset at beat 10 of a write to line 9
        w_MS_REQ = 1'b1; w_MS_WRITE = 1'b1; w_MS_ADDR = 5'd9; w_MS_DATA_IN = 1'b1;
        tick();
        w_MS_REQ = 1'b0;
        n = 0;
        while (!(w_MS_DATA_VALID === 1'b1 && w_BEAT === 5'd10) && n < 80) begin tick(); n++; end
        check("midwrite_at_beat10", {26'd0, w_MS_DATA_VALID, w_BEAT}, {26'd0, 1'b1, 5'd10});
        w_RST_N = 1'b0;
        #1;
        check("midrst_state", {26'd0, w_MS_BUSY, w_MS_DATA_VALID, w_MS_DONE, w_MS_DATA_OUT, 1'b0, 1'b0},
              32'd0);
        check("midrst_beat", {27'd0, w_BEAT}, 32'd0);
        w_MS_DATA_IN = 1'b0;
        tick(); tick();
        w_RST_N = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (w_MS_DONE === 1'b1 || w_MS_BUSY === 1'b1) dones++;
            tick();
        end
        check("midrst_no_done", dones, 0);
        xfer(1'b0, 5'd9, 32'h0, 32'h0, 1'b0, rd);
        check("line9_cleared", rd, 32'h0);
        xfer(1'b0, 5'd5, 32'h0, 32'h0, 1'b0, rd);
        check("line5_cleared", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
